// File: rtl/riscv_regmap_bridge.sv
// ICB slave to DPU regmap bridge with a timed regmap read path and a local edge-latched interrupt bank.
// Latency: regmap write rsp at T+2, regmap read rsp one cycle after rdata_act (or timeout), local/bad-mask rsp at T+1.
// Backpressure: one transaction outstanding; cmd_ready only in IDLE, response held stable until rsp_ready.
module riscv_regmap_bridge #(
  parameter int DPU_REG_ADDR_WTH = 13,
  parameter int DPU_REG_DATA_WTH = 32,
  parameter int ICB_ADDR_WTH     = 32,
  parameter int INTR_NUM         = 8,
  parameter int RD_TIMEOUT       = 255
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        icb_cmd_valid_i,
  output logic                        icb_cmd_ready_o,
  input  logic [ICB_ADDR_WTH-1:0]     icb_cmd_addr_i,
  input  logic                        icb_cmd_read_i,
  input  logic [DPU_REG_DATA_WTH-1:0] icb_cmd_wdata_i,
  input  logic [3:0]                  icb_cmd_wmask_i,
  output logic                        icb_rsp_valid_o,
  input  logic                        icb_rsp_ready_i,
  output logic                        icb_rsp_err_o,
  output logic [DPU_REG_DATA_WTH-1:0] icb_rsp_rdata_o,
  output logic [DPU_REG_ADDR_WTH-1:0] riscv_regmap__waddr_o,
  output logic                        riscv_regmap__we_o,
  output logic [DPU_REG_DATA_WTH-1:0] riscv_regmap__wdata_o,
  output logic [DPU_REG_ADDR_WTH-1:0] riscv_regmap__raddr_o,
  output logic                        riscv_regmap__re_o,
  input  logic [DPU_REG_DATA_WTH-1:0] riscv_regmap__rdata_i,
  input  logic                        riscv_regmap__rdata_act_i,
  input  logic [INTR_NUM-1:0]         riscv_regmap__intr_i,
  output logic                        intr_o
);

  localparam int AW = DPU_REG_ADDR_WTH;
  localparam int DW = DPU_REG_DATA_WTH;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WR      = 2'd1;
  localparam logic [1:0] ST_RD_WAIT = 2'd2;
  localparam logic [1:0] ST_RSP     = 2'd3;

  localparam logic [15:0]   TO_CNT = 16'(RD_TIMEOUT);
  localparam logic [AW-1:0] W_PEND = AW'(0);
  localparam logic [AW-1:0] W_MASK = AW'(1);
  localparam logic [AW-1:0] W_CLR  = AW'(2);

  logic [1:0]          state_q, state_d;
  logic [AW-1:0]       waddr_q, waddr_d;
  logic [AW-1:0]       raddr_q, raddr_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [DW-1:0]       rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic [INTR_NUM-1:0] pend_q, pend_d;
  logic [INTR_NUM-1:0] mask_q, mask_d;
  logic [INTR_NUM-1:0] intr_s_q, intr_h_q;
  logic                intr_q, intr_d;

  logic                cmd_hs;
  logic                is_local;
  logic [AW-1:0]       word;
  logic [INTR_NUM-1:0] pend_clr;
  logic [INTR_NUM-1:0] rise;
  logic [DW-1:0]       pend_ext, mask_ext;

  // Byte address bits outside the word index are not decoded.
  logic unused_addr;
  assign unused_addr = ^icb_cmd_addr_i;

  assign cmd_hs   = icb_cmd_valid_i && (state_q == ST_IDLE);
  assign is_local = icb_cmd_addr_i[AW+2];
  assign word     = icb_cmd_addr_i[AW+1:2];
  assign rise     = intr_s_q & ~intr_h_q;

  assign icb_cmd_ready_o       = (state_q == ST_IDLE);
  assign icb_rsp_valid_o       = (state_q == ST_RSP);
  assign icb_rsp_err_o         = rsp_err_q;
  assign icb_rsp_rdata_o       = rsp_rdata_q;
  assign riscv_regmap__waddr_o = waddr_q;
  assign riscv_regmap__wdata_o = wdata_q;
  assign riscv_regmap__raddr_o = raddr_q;
  assign riscv_regmap__we_o    = (state_q == ST_WR);
  // Counter is cleared on entry, so zero marks the first RD_WAIT cycle.
  assign riscv_regmap__re_o    = (state_q == ST_RD_WAIT) && (cnt_q == 16'd0);
  assign intr_o                = intr_q;

  // Zero-extend the interrupt registers to bus width for local reads.
  always_comb begin
    pend_ext = '0;
    mask_ext = '0;
    pend_ext[INTR_NUM-1:0] = pend_q;
    mask_ext[INTR_NUM-1:0] = mask_q;
  end

  // Transaction FSM: decode, regmap strobes, read timeout and local bank access.
  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    raddr_d     = raddr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mask_d      = mask_q;
    pend_clr    = '0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_hs) begin
          if (is_local) begin
            state_d     = ST_RSP;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b0;
            if (word == W_PEND) begin
              if (icb_cmd_read_i) rsp_rdata_d = pend_ext;
            end else if (word == W_MASK) begin
              if (icb_cmd_read_i) rsp_rdata_d = mask_ext;
              else                mask_d      = icb_cmd_wdata_i[INTR_NUM-1:0];
            end else if (word == W_CLR) begin
              if (!icb_cmd_read_i) pend_clr = icb_cmd_wdata_i[INTR_NUM-1:0];
            end else begin
              rsp_err_d = 1'b1;
            end
          end else if (icb_cmd_read_i) begin
            state_d = ST_RD_WAIT;
            raddr_d = word;
            cnt_d   = 16'd0;
          end else if (icb_cmd_wmask_i == 4'hF) begin
            state_d = ST_WR;
            waddr_d = word;
            wdata_d = icb_cmd_wdata_i;
          end else begin
            // Partial writes are not supported by the regmap.
            state_d     = ST_RSP;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
          end
        end
      end
      ST_WR: begin
        state_d     = ST_RSP;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
      end
      ST_RD_WAIT: begin
        if (riscv_regmap__rdata_act_i) begin
          state_d     = ST_RSP;
          rsp_rdata_d = riscv_regmap__rdata_i;
          rsp_err_d   = 1'b0;
        end else if (cnt_q == TO_CNT) begin
          state_d     = ST_RSP;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        if (icb_rsp_ready_i) state_d = ST_IDLE;
      end
    endcase
  end

  // Edge-latched pending bits; a new rising edge wins over a same-cycle clear.
  always_comb begin
    pend_d = (pend_q & ~pend_clr) | rise;
    intr_d = |(pend_q & mask_q);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      waddr_q     <= '0;
      raddr_q     <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      pend_q      <= '0;
      mask_q      <= '0;
      intr_s_q    <= '0;
      intr_h_q    <= '0;
      intr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      waddr_q     <= waddr_d;
      raddr_q     <= raddr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      pend_q      <= pend_d;
      mask_q      <= mask_d;
      intr_s_q    <= riscv_regmap__intr_i;
      intr_h_q    <= intr_s_q;
      intr_q      <= intr_d;
    end
  end

endmodule

// File: tb/tb_riscv_regmap_bridge.sv
// Directed bench for riscv_regmap_bridge (RD_TIMEOUT = 4).
// Inputs driven and outputs sampled 1 time unit after each rising edge.
// Each task checks its own scenario against hand-computed values.
module tb_riscv_regmap_bridge;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic        cmd_read = 1'b0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wmask = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [12:0] waddr, raddr;
  logic        we, re;
  logic [31:0] wdata;
  logic [31:0] rm_rdata = '0;
  logic        rm_act = 1'b0;
  logic [7:0]  intr_in = '0;
  logic        intr_out;

  int total = 0;
  int bad = 0;

  riscv_regmap_bridge #(
    .DPU_REG_ADDR_WTH(13), .DPU_REG_DATA_WTH(32), .ICB_ADDR_WTH(32),
    .INTR_NUM(8), .RD_TIMEOUT(4)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .icb_cmd_valid_i(cmd_valid), .icb_cmd_ready_o(cmd_ready),
    .icb_cmd_addr_i(cmd_addr), .icb_cmd_read_i(cmd_read),
    .icb_cmd_wdata_i(cmd_wdata), .icb_cmd_wmask_i(cmd_wmask),
    .icb_rsp_valid_o(rsp_valid), .icb_rsp_ready_i(rsp_ready),
    .icb_rsp_err_o(rsp_err), .icb_rsp_rdata_o(rsp_rdata),
    .riscv_regmap__waddr_o(waddr), .riscv_regmap__we_o(we),
    .riscv_regmap__wdata_o(wdata), .riscv_regmap__raddr_o(raddr),
    .riscv_regmap__re_o(re), .riscv_regmap__rdata_i(rm_rdata),
    .riscv_regmap__rdata_act_i(rm_act), .riscv_regmap__intr_i(intr_in),
    .intr_o(intr_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a command; returns in cycle T+1 where T is the handshake edge.
  task automatic issue(input logic [31:0] a, input logic rd, input logic [31:0] d, input logic [3:0] m);
    cmd_addr = a; cmd_read = rd; cmd_wdata = d; cmd_wmask = m; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic accept();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    total++; if ({rsp_valid, rsp_err, we, re, intr_out} !== 5'b0) begin bad++; $display("FAIL reset_ctl got=%b exp=00000", {rsp_valid, rsp_err, we, re, intr_out}); end
    total++; if ({rsp_rdata, wdata, waddr, raddr} !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", {rsp_rdata, wdata, waddr, raddr}); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_write();
    issue(32'h10, 1'b0, 32'hDEADBEEF, 4'hF);
    total++; if ({we, rsp_valid} !== 2'b10) begin bad++; $display("FAIL wr_t1_strobe got=%b exp=10", {we, rsp_valid}); end
    total++; if (waddr !== 13'd4 || wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_t1_addr_data got=%h/%h exp=0004/deadbeef", waddr, wdata); end
    step();
    total++; if ({we, rsp_valid, rsp_err} !== 3'b010) begin bad++; $display("FAIL wr_t2_rsp got=%b exp=010", {we, rsp_valid, rsp_err}); end
    accept();
    total++; if ({rsp_valid, cmd_ready} !== 2'b01) begin bad++; $display("FAIL wr_idle got=%b exp=01", {rsp_valid, cmd_ready}); end
  endtask

  task automatic test_read();
    rm_rdata = 32'h1234;
    issue(32'h20, 1'b1, 32'h0, 4'hF);
    total++; if (re !== 1'b1 || raddr !== 13'd8) begin bad++; $display("FAIL rd_t1_strobe got=%b/%h exp=1/0008", re, raddr); end
    step();
    total++; if (re !== 1'b0) begin bad++; $display("FAIL rd_single_strobe got=%b exp=0", re); end
    step();
    step();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_t4_early got=%b exp=0", rsp_valid); end
    rm_act = 1'b1;
    step();
    rm_act = 1'b0;
    total++; if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h1234) begin bad++; $display("FAIL rd_t5_rsp got=%b/%h exp=10/00001234", {rsp_valid, rsp_err}, rsp_rdata); end
    rm_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h1234) begin bad++; $display("FAIL rd_hold%0d got=%b/%h exp=10/00001234", i, {rsp_valid, rsp_err}, rsp_rdata); end
    end
    accept();
  endtask

  task automatic test_timeout();
    issue(32'h40, 1'b1, 32'h0, 4'hF);
    for (int i = 1; i <= 5; i++) begin
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL to_early_t%0d got=%b exp=0", i, rsp_valid); end
      step();
    end
    total++; if ({rsp_valid, rsp_err} !== 2'b11 || rsp_rdata !== 32'h0) begin bad++; $display("FAIL to_t6_rsp got=%b/%h exp=11/00000000", {rsp_valid, rsp_err}, rsp_rdata); end
    accept();
    rm_rdata = 32'hA5A5_0001;
    issue(32'h44, 1'b1, 32'h0, 4'hF);
    rm_act = 1'b1;
    total++; if (re !== 1'b1 || raddr !== 13'd17) begin bad++; $display("FAIL to_next_strobe got=%b/%h exp=1/0011", re, raddr); end
    step();
    rm_act = 1'b0;
    total++; if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'hA5A5_0001) begin bad++; $display("FAIL to_next_rsp got=%b/%h exp=10/a5a50001", {rsp_valid, rsp_err}, rsp_rdata); end
    accept();
  endtask

  task automatic test_bad_mask();
    issue(32'h10, 1'b0, 32'h1111_2222, 4'h3);
    total++; if ({we, rsp_valid, rsp_err} !== 3'b011) begin bad++; $display("FAIL badmask got=%b exp=011", {we, rsp_valid, rsp_err}); end
    accept();
    total++; if (we !== 1'b0) begin bad++; $display("FAIL badmask_no_we got=%b exp=0", we); end
  endtask

  task automatic test_intr();
    intr_in = 8'h20;
    step();
    intr_in = 8'h00;
    step(); step(); step();
    total++; if (intr_out !== 1'b0) begin bad++; $display("FAIL intr_masked got=%b exp=0", intr_out); end
    issue(32'h8000, 1'b1, 32'h0, 4'hF);
    total++; if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h20) begin bad++; $display("FAIL pend_read got=%b/%h exp=10/00000020", {rsp_valid, rsp_err}, rsp_rdata); end
    accept();
    issue(32'h8004, 1'b0, 32'h20, 4'h0);
    total++; if ({rsp_valid, rsp_err} !== 2'b10) begin bad++; $display("FAIL mask_write got=%b exp=10", {rsp_valid, rsp_err}); end
    accept();
    total++; if (intr_out !== 1'b1) begin bad++; $display("FAIL intr_unmasked got=%b exp=1", intr_out); end
    issue(32'h8004, 1'b1, 32'h0, 4'hF);
    total++; if (rsp_rdata !== 32'h20) begin bad++; $display("FAIL mask_read got=%h exp=00000020", rsp_rdata); end
    accept();
    // New edge sampled one edge before the CLR handshake, so set and clear coincide.
    intr_in = 8'h20;
    step();
    issue(32'h8008, 1'b0, 32'h20, 4'hF);
    intr_in = 8'h00;
    accept();
    issue(32'h8000, 1'b1, 32'h0, 4'hF);
    total++; if (rsp_rdata !== 32'h20) begin bad++; $display("FAIL set_wins got=%h exp=00000020", rsp_rdata); end
    accept();
    total++; if (intr_out !== 1'b1) begin bad++; $display("FAIL set_wins_intr got=%b exp=1", intr_out); end
    issue(32'h8008, 1'b0, 32'h20, 4'hF);
    accept();
    issue(32'h8000, 1'b1, 32'h0, 4'hF);
    total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL clr_pend got=%h exp=00000000", rsp_rdata); end
    accept();
    total++; if (intr_out !== 1'b0) begin bad++; $display("FAIL clr_intr got=%b exp=0", intr_out); end
    // Edge sampled at E: intr_o must be low after E and E+1, high after E+2.
    intr_in = 8'h20;
    step();
    intr_in = 8'h00;
    total++; if (intr_out !== 1'b0) begin bad++; $display("FAIL intr_e0 got=%b exp=0", intr_out); end
    step();
    total++; if (intr_out !== 1'b0) begin bad++; $display("FAIL intr_e1 got=%b exp=0", intr_out); end
    step();
    total++; if (intr_out !== 1'b1) begin bad++; $display("FAIL intr_e2 got=%b exp=1", intr_out); end
  endtask

  task automatic test_bad_local();
    issue(32'h800C, 1'b1, 32'h0, 4'hF);
    total++; if ({rsp_valid, rsp_err} !== 2'b11 || rsp_rdata !== 32'h0) begin bad++; $display("FAIL local_w3 got=%b/%h exp=11/00000000", {rsp_valid, rsp_err}, rsp_rdata); end
    accept();
  endtask

  task automatic test_back_to_back();
    issue(32'h100, 1'b0, 32'h0BAD_F00D, 4'hF);
    step();
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL b2b_wr_rsp got=%b exp=1", rsp_valid); end
    rsp_ready = 1'b1;
    cmd_addr = 32'h104; cmd_read = 1'b1; cmd_valid = 1'b1;
    step();
    rsp_ready = 1'b0;
    total++; if ({rsp_valid, cmd_ready, re} !== 3'b010) begin bad++; $display("FAIL b2b_idle got=%b exp=010", {rsp_valid, cmd_ready, re}); end
    step();
    cmd_valid = 1'b0;
    total++; if (re !== 1'b1 || raddr !== 13'h41) begin bad++; $display("FAIL b2b_rd_strobe got=%b/%h exp=1/0041", re, raddr); end
    rm_rdata = 32'h7;
    rm_act = 1'b1;
    step();
    rm_act = 1'b0;
    total++; if (rsp_rdata !== 32'h7) begin bad++; $display("FAIL b2b_rd_data got=%h exp=00000007", rsp_rdata); end
    accept();
  endtask

  task automatic test_reset_abort();
    issue(32'h30, 1'b1, 32'h0, 4'hF);
    total++; if (re !== 1'b1) begin bad++; $display("FAIL abort_strobe got=%b exp=1", re); end
    rst = 1'b1;
    step();
    total++; if ({cmd_ready, rsp_valid, re, we, rsp_err, intr_out} !== 6'b100000) begin bad++; $display("FAIL abort_ctl got=%b exp=100000", {cmd_ready, rsp_valid, re, we, rsp_err, intr_out}); end
    total++; if ({raddr, rsp_rdata} !== '0) begin bad++; $display("FAIL abort_data got=%h exp=0", {raddr, rsp_rdata}); end
    step();
    rst = 1'b0;
    rm_act = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      total++; if ({rsp_valid, re} !== 2'b00) begin bad++; $display("FAIL abort_no_rsp%0d got=%b exp=00", i, {rsp_valid, re}); end
    end
    rm_act = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_bad_mask();
    test_intr();
    test_bad_local();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
